clock_time_counter: RTL and testbench
=====================================

// Module: clock_time_counter
// PURPOSE
//   Timekeeping core of the clock: divides the system clock to a 1 Hz enable and
//   keeps 24-hour time HH:MM:SS as six registered BCD digits, with a set mode.
//   Each digit output feeds one 4-bit digit input of the seven-segment encoder;
//   every digit is always 0..9, so the encoder's blank default is never hit.
// PARAMETERS
//   CLK_HZ   50_000_000   system clock frequency; prescaler period in cycles (>=2)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   set_mode   in   1  1 = time-set mode (time frozen), 0 = run
//   inc_min    in   1  level from debounced button; +1 minute per rising edge
//   inc_hour   in   1  level from debounced button; +1 hour per rising edge
//   hour_tens  out  4  BCD 0..2
//   hour_ones  out  4  BCD 0..9 (0..3 when hour_tens==2)
//   min_tens   out  4  BCD 0..5
//   min_ones   out  4  BCD 0..9
//   sec_tens   out  4  BCD 0..5
//   sec_ones   out  4  BCD 0..9
//   sec_tick   out  1  one-cycle pulse, 1 Hz, registered
// BEHAVIOUR
//   Reset: all digits 0 (00:00:00), sec_tick 0, prescaler 0, edge-detect regs 0.
//     rst has priority over every other input in the same cycle.
//   Prescaler: counts 0..CLK_HZ-1 in run mode; sec_tick=1 for the cycle after
//     the count equals CLK_HZ-1, count wraps to 0. First tick after reset/after
//     leaving set mode appears exactly CLK_HZ cycles later.
//   Run mode (set_mode=0): on the cycle sec_tick is generated, time advances by
//     1 s; digits change 1 cycle after the counting edge (same cycle sec_tick=1).
//     Carries: sec_ones 9->0 incs sec_tens; 59 s -> 00 incs minutes; 59 min -> 00
//     incs hours; 23:59:59 -> 00:00:00. All carries resolve in the same cycle.
//     inc_min/inc_hour edges are ignored (edge regs still track inputs).
//   Set mode (set_mode=1): prescaler held at 0, sec_tick held 0, seconds forced
//     to 00 from the first set-mode cycle. Rising edge of inc_min (input 1, prev
//     0): minutes +1 mod 60, no carry into hours. Rising edge of inc_hour: hours
//     +1 mod 24. Simultaneous edges: both applied in the same cycle. A held-high
//     button yields exactly one increment.
//   Edge detect: prev registers sample inputs every cycle; an input already high
//     when set mode is entered does not count as an edge.
//   Invariants (never violated, incl. after reset mid-operation): each digit <=9,
//     tens of min/sec <=5, hours <=23.
// STRUCTURE
//   Package clock_pkg: typedef logic [3:0] bcd_t; localparams SEC_MOD=60,
//     MIN_MOD=60, HOUR_MOD=24; struct time_bcd_t {hour,min,sec pairs}.
//   Sub-module bcd_mod_counter #(MODULUS): two-digit BCD counter with clk, rst,
//     clr, inc -> tens, ones, carry (combinational: inc && value==MODULUS-1).
//     Instantiated three times (sec/min/hour); top holds prescaler, edge detect,
//     mode muxing of inc/clr.
// TESTING  (CLK_HZ=4 for simulation)
//   Reset then run 40 cycles -> sec_tick every 4th cycle, time 00:00:10.
//   Preload via set mode to 23:59, exit, run 60 s -> 23:59:59 then 00:00:00
//     on next tick, all six digits change in one cycle.
//   Set mode, pulse inc_min 61 times -> min 01, hours unchanged; inc_hour 25x
//     -> hour 01; inc_hour held high 10 cycles -> exactly +1.
//   Set mode with time 00:00:37 -> seconds 00 next cycle, no sec_tick while set;
//     exit -> first sec_tick exactly 4 cycles later.
//   inc_min and inc_hour rising together in set mode at 09:59 -> 10:00? no:
//     -> 10:00 only via separate fields: hour 10, min 00 (no carry) in one cycle.
//   Assert rst mid-count at 12:34:56 -> 00:00:00, sec_tick 0 next cycle;
//     digit-range assertions hold throughout random set/run stimulus.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD types and field moduli for the time-of-day counter
package clock_pkg;
   typedef logic [3:0] bcd_t;
   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HOUR_MOD = 24;
   typedef struct packed {
      bcd_t hour_tens;
      bcd_t hour_ones;
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } time_bcd_t;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MODULUS with clear and carry-out
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MODULUS = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output bcd_t tens,
   output bcd_t ones,
   output logic carry
);
   localparam bcd_t MAX_T = bcd_t'((MODULUS - 1) / 10);
   localparam bcd_t MAX_O = bcd_t'((MODULUS - 1) % 10);
   bcd_t tens_q, tens_d, ones_q, ones_d;
   assign carry = inc && tens_q == MAX_T && ones_q == MAX_O;
   assign tens  = tens_q;
   assign ones  = ones_q;
   // next value: clear wins, then wrap on terminal count, else BCD increment
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr || carry) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc) begin
         ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
         tens_d = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
      end
   end
   // digit registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end
endmodule

// File: rtl/clock_time_counter.sv
// clock_time_counter: 1 Hz prescaler plus 24-hour BCD time with button set mode
module clock_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic set_mode,
   input  logic inc_min,
   input  logic inc_hour,
   output bcd_t hour_tens,
   output bcd_t hour_ones,
   output bcd_t min_tens,
   output bcd_t min_ones,
   output bcd_t sec_tens,
   output bcd_t sec_ones,
   output logic sec_tick
);
   localparam int CW = $clog2(CLK_HZ);
   logic [CW-1:0] cnt_q, cnt_d;
   logic tick_q, tick_d, min_prev_q, hour_prev_q;
   logic term, min_edge, hour_edge, min_inc, hour_inc, sec_carry, min_carry;
   logic unused_hour_carry;
   assign term      = cnt_q == CW'(CLK_HZ - 1);
   assign min_edge  = inc_min && !min_prev_q;
   assign hour_edge = inc_hour && !hour_prev_q;
   assign min_inc   = set_mode ? min_edge : sec_carry;
   assign hour_inc  = set_mode ? hour_edge : min_carry;
   assign sec_tick  = tick_q;
   // prescaler holds at zero while setting so the first run tick is a full period away
   always_comb begin
      cnt_d  = (set_mode || term) ? '0 : cnt_q + CW'(1);
      tick_d = !set_mode && term;
   end
   // prescaler, tick and button history registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         min_prev_q  <= 1'b0;
         hour_prev_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         min_prev_q  <= inc_min;
         hour_prev_q <= inc_hour;
      end
   end
   bcd_mod_counter #(.MODULUS(SEC_MOD)) u_sec (
      .clk(clk), .rst(rst), .clr(set_mode), .inc(tick_d),
      .tens(sec_tens), .ones(sec_ones), .carry(sec_carry)
   );
   bcd_mod_counter #(.MODULUS(MIN_MOD)) u_min (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(min_inc),
      .tens(min_tens), .ones(min_ones), .carry(min_carry)
   );
   bcd_mod_counter #(.MODULUS(HOUR_MOD)) u_hour (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(hour_inc),
      .tens(hour_tens), .ones(hour_ones), .carry(unused_hour_carry)
   );
endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: randomized and directed checks against a seconds-of-day model
module tb_clock_time_counter;
   localparam int HZ = 4;
   logic clk = 0, rst = 1, set_mode = 0, inc_min = 0, inc_hour = 0;
   logic [3:0] ht, ho, mt, mo, st, so;
   logic sec_tick;
   logic [23:0] dut_time;
   int checks = 0, failures = 0;
   int m_t = 0, m_phase = 0;
   bit m_tick = 0, m_pm = 0, m_ph = 0;
   assign dut_time = {ht, ho, mt, mo, st, so};
   always #5 clk = ~clk;
   clock_time_counter #(.CLK_HZ(HZ)) dut (
      .clk(clk), .rst(rst), .set_mode(set_mode), .inc_min(inc_min), .inc_hour(inc_hour),
      .hour_tens(ht), .hour_ones(ho), .min_tens(mt), .min_ones(mo),
      .sec_tens(st), .sec_ones(so), .sec_tick(sec_tick)
   );
   function automatic logic [23:0] to_bcd(int t);
      int h = t / 3600, m = (t / 60) % 60, s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction
   task automatic step();
      int h, m;
      @(posedge clk);
      if (rst) begin
         m_t = 0; m_phase = 0; m_tick = 0;
      end else if (set_mode) begin
         h = m_t / 3600;
         m = (m_t / 60) % 60;
         if (inc_min && !m_pm) m = (m + 1) % 60;
         if (inc_hour && !m_ph) h = (h + 1) % 24;
         m_t = h * 3600 + m * 60; m_phase = 0; m_tick = 0;
      end else begin
         m_phase++;
         m_tick = (m_phase == HZ);
         if (m_tick) begin
            m_phase = 0;
            m_t = (m_t + 1) % 86400;
         end
      end
      m_pm = rst ? 1'b0 : inc_min;
      m_ph = rst ? 1'b0 : inc_hour;
      #1;
   endtask
   task automatic press(input bit hour);
      if (hour) inc_hour = 1; else inc_min = 1;
      step();
      inc_hour = 0; inc_min = 0;
      step();
   endtask
   task automatic test_reset();
      rst = 1; set_mode = 0;
      step(); step();
      checks++;
      if (dut_time !== 24'h000000) begin failures++; $display("FAIL reset_time: got %h want 000000", dut_time); end
      checks++;
      if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", sec_tick); end
      rst = 0;
   endtask
   task automatic test_run();
      int ticks = 0;
      repeat (40) begin
         step();
         checks++;
         if (sec_tick !== m_tick) begin failures++; $display("FAIL run_tick: got %b want %b", sec_tick, m_tick); end
         if (sec_tick) ticks++;
      end
      checks++;
      if (ticks != 10) begin failures++; $display("FAIL run_tick_count: got %0d want 10", ticks); end
      checks++;
      if (dut_time !== 24'h000010) begin failures++; $display("FAIL run_time: got %h want 000010", dut_time); end
   endtask
   task automatic test_preload_wrap();
      int ticks = 0;
      logic [23:0] prev;
      set_mode = 1;
      step();
      repeat (23) press(1);
      repeat (59) press(0);
      checks++;
      if (dut_time !== 24'h235900) begin failures++; $display("FAIL preload: got %h want 235900", dut_time); end
      set_mode = 0;
      repeat (60 * HZ) begin
         prev = dut_time;
         step();
         checks++;
         if (dut_time !== to_bcd(m_t) || sec_tick !== m_tick) begin
            failures++; $display("FAIL wrap_model: got %h/%b want %h/%b", dut_time, sec_tick, to_bcd(m_t), m_tick);
         end
         if (sec_tick) ticks++;
         if (sec_tick && ticks == 59) begin
            checks++;
            if (dut_time !== 24'h235959) begin failures++; $display("FAIL wrap_235959: got %h want 235959", dut_time); end
         end
         if (sec_tick && ticks == 60) begin
            checks++;
            if (prev !== 24'h235959 || dut_time !== 24'h000000) begin
               failures++; $display("FAIL wrap_midnight: got %h->%h want 235959->000000", prev, dut_time);
            end
         end
      end
      checks++;
      if (ticks != 60) begin failures++; $display("FAIL wrap_ticks: got %0d want 60", ticks); end
   endtask
   task automatic test_set_incs();
      set_mode = 1;
      step();
      repeat (61) press(0);
      checks++;
      if (dut_time !== 24'h000100) begin failures++; $display("FAIL set_min61: got %h want 000100", dut_time); end
      repeat (25) press(1);
      checks++;
      if (dut_time !== 24'h010100) begin failures++; $display("FAIL set_hour25: got %h want 010100", dut_time); end
      inc_hour = 1;
      repeat (10) step();
      inc_hour = 0;
      step();
      checks++;
      if (dut_time !== 24'h020100) begin failures++; $display("FAIL set_hold: got %h want 020100", dut_time); end
   endtask
   task automatic test_seconds_clear();
      int n = 0;
      rst = 1; set_mode = 0;
      step();
      rst = 0;
      repeat (37 * HZ) step();
      checks++;
      if (dut_time !== 24'h000037) begin failures++; $display("FAIL sec37: got %h want 000037", dut_time); end
      set_mode = 1;
      step();
      checks++;
      if (dut_time !== 24'h000000 || sec_tick !== 1'b0) begin
         failures++; $display("FAIL sec_clear: got %h/%b want 000000/0", dut_time, sec_tick);
      end
      repeat (2 * HZ) begin
         step();
         checks++;
         if (sec_tick !== 1'b0) begin failures++; $display("FAIL set_no_tick: got %b want 0", sec_tick); end
      end
      set_mode = 0;
      do begin step(); n++; end while (!sec_tick && n < 20);
      checks++;
      if (n != HZ || sec_tick !== 1'b1) begin failures++; $display("FAIL first_tick: got %0d cycles want %0d", n, HZ); end
   endtask
   task automatic test_simultaneous();
      rst = 1;
      step();
      rst = 0; set_mode = 1;
      step();
      repeat (9) press(1);
      repeat (59) press(0);
      checks++;
      if (dut_time !== 24'h095900) begin failures++; $display("FAIL simul_pre: got %h want 095900", dut_time); end
      inc_min = 1; inc_hour = 1;
      step();
      checks++;
      if (dut_time !== 24'h100000) begin failures++; $display("FAIL simul_edge: got %h want 100000", dut_time); end
      inc_min = 0; inc_hour = 0;
      step();
   endtask
   task automatic test_reset_mid();
      rst = 1;
      step();
      rst = 0; set_mode = 1;
      step();
      repeat (12) press(1);
      repeat (34) press(0);
      set_mode = 0;
      repeat (56 * HZ) step();
      checks++;
      if (dut_time !== 24'h123456) begin failures++; $display("FAIL pre_reset: got %h want 123456", dut_time); end
      step(); step();
      rst = 1; inc_min = 1; set_mode = 1;
      step();
      checks++;
      if (dut_time !== 24'h000000 || sec_tick !== 1'b0) begin
         failures++; $display("FAIL mid_reset: got %h/%b want 000000/0", dut_time, sec_tick);
      end
      rst = 0; inc_min = 0; set_mode = 0;
      step();
   endtask
   task automatic test_random();
      repeat (3000) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0) set_mode = ~set_mode;
         inc_min = ($urandom_range(0, 2) == 0);
         inc_hour = ($urandom_range(0, 2) == 0);
         step();
         checks++;
         if (dut_time !== to_bcd(m_t) || sec_tick !== m_tick) begin
            failures++; $display("FAIL random_model: got %h/%b want %h/%b", dut_time, sec_tick, to_bcd(m_t), m_tick);
         end
         checks++;
         if (ht > 2 || ho > 9 || (ht == 2 && ho > 3) || mt > 5 || mo > 9 || st > 5 || so > 9) begin
            failures++; $display("FAIL digit_range: got %h want valid 24h BCD", dut_time);
         end
      end
      rst = 0; set_mode = 0; inc_min = 0; inc_hour = 0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_run();
      test_preload_wrap();
      test_set_incs();
      test_seconds_clear();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
